cmd_record_loader: RTL and testbench
====================================

# cmd_record_loader

Parametrised TRS-80 /CMD record parser between `hps_io` ioctl download and the machine RAM download port. It decodes load-module records, writes data records through a RAM write handshake with backpressure, skips non-data records, captures the transfer address and optionally triggers execution. It also reports malformed or truncated files. It generalises the existing CMD loader with configurable address width, a selectable ioctl index, RAM-side acknowledge and error reporting.

## Interface
Parameters:
- `ADDR_W`, 16: width of `ld_addr`. Must be ≥16; bits above 15 are driven 0.
- `INDEX`, 8'd2: `ioctl_index` value that selects this loader.
- `AUTO_EXEC`, 1: 1 = pulse `execute_enable` after a valid transfer record; 0 = never pulse it.

Ports:
- `clk_sys` in 1: system clock. All logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download in progress.
- `ioctl_index` in 8: download slot.
- `ioctl_wr` in 1: byte strobe, one cycle.
- `ioctl_dout` in 8: byte value.
- `ioctl_wait` out 1: registered; tells `hps_io` to hold the next byte.
- `ld_wr` out 1: RAM write request, held until acknowledged.
- `ld_addr` out ADDR_W: RAM write address.
- `ld_data` out 8: RAM write data.
- `ld_ack` in 1: RAM accepted the write in this cycle.
- `loader_download` out 1: loader active; selects the loader path at the RAM mux.
- `execute_addr` out 16: captured transfer address.
- `execute_enable` out 1: one-cycle start pulse.
- `error` out 1: sticky; set on malformed or truncated file, cleared at next download start.

## Operation
- The block starts when `ioctl_download` rises while `ioctl_index==INDEX`. On start: state TYPE, `error`←0, `loader_download`←1. Downloads on other indices are ignored entirely.
- A byte is consumed only on `ioctl_wr=1` while `ioctl_wait=0`.
- States: IDLE, TYPE, LEN, ADLO, ADHI, DATA, WRITE, XLO, XHI, SKIP, DONE.
- TYPE: byte 0x01 → LEN (data record); 0x02 → LEN (transfer record); any other value → LEN (skip record).
- LEN, data record: count = (L−2) mod 256, where 0 means 256. So L=2→256, L=0→254, L=1→255, L=3→1. Next state ADLO.
- LEN, transfer record: next state XLO; the length value is ignored.
- LEN, skip record: count = L, where 0 means 256. Next state SKIP.
- ADLO/ADHI: load the 16-bit address, low byte first. Next state DATA.
- DATA: present byte on `ld_data` at the current address, assert `ld_wr`, go to WRITE.
- WRITE: on `ld_ack`, address increments (wraps 0xFFFF→0x0000) and count decrements. Then DATA if count>0, else TYPE.
- SKIP: discard bytes until count reaches 0, then TYPE.
- XLO/XHI: capture `execute_addr`, low byte first, then DONE.
- DONE: all further bytes are consumed and ignored.
- End of download (`ioctl_download` low, no write pending):
  - State DONE: `loader_download`←0. If AUTO_EXEC, pulse `execute_enable`.
  - State TYPE, or file had no transfer record: `loader_download`←0, no pulse, `error` unchanged.
  - Any other state (truncated record): `error`←1, `loader_download`←0, no pulse.
- Download falling while in WRITE: the pending write completes first, then the end-of-download rules apply.

## Timing
- Reset values: all outputs 0; state IDLE.
- `loader_download` goes high 1 cycle after the qualifying `ioctl_download` rise.
- Data byte strobe in cycle N → `ld_wr`, `ld_addr`, `ld_data` valid and `ioctl_wait`=1 in cycle N+1.
- `ld_wr` and its address/data are held stable until `ld_ack` is sampled high.
- `ld_ack` in cycle K → `ld_wr`=0 and `ioctl_wait`=0 in K+1. Minimum 2-cycle byte throughput.
- `ld_ack` while `ld_wr`=0 is ignored.
- Header, skip and transfer bytes never raise `ioctl_wait`.
- `execute_enable` is high for exactly 1 cycle, coincident with the cycle `loader_download` falls. `execute_addr` holds its value until the next download start.
- `reset_n` low at any point aborts the download immediately. No `ld_wr` is issued after reset is released until a new download starts.

## Test plan
- Bytes 01 05 00 80 AA BB CC 02 02 00 80 with `ld_ack` 1 cycle after each `ld_wr` → writes AA@8000, BB@8001, CC@8002; `execute_addr`=8000; one `execute_enable` pulse; `error`=0.
- Data record with L=02 at address 7000 → 256 writes covering 7000–70FF. Repeat with L=00 → 254 writes.
- Record 05 03 41 42 43 before a data record → no writes for the skipped bytes; following record loads normally.
- `ld_ack` delayed 5 cycles → `ioctl_wait` high for the whole delay; `ld_addr`/`ld_data` stable; no byte lost or duplicated.
- Download ends after ADHI → `error`=1, no `execute_enable`. Next download clears `error`.
- Address FFFF with 2 data bytes → writes at FFFF then 0000. Separately, `reset_n` pulsed mid-WRITE → all outputs 0, no further `ld_wr`.

Source files
------------

// File: rtl/cmd_record_loader_if.sv
// Bus bundle between hps_io ioctl download, the /CMD record loader and the
// machine RAM download port.
interface cmd_record_loader_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [7:0]        ioctl_dout;
   logic              ioctl_wait;
   logic              ld_wr;
   logic [ADDR_W-1:0] ld_addr;
   logic [7:0]        ld_data;
   logic              ld_ack;
   logic              loader_download;
   logic [15:0]       execute_addr;
   logic              execute_enable;
   logic              error;

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, ld_ack,
      input  ioctl_wait, ld_wr, ld_addr, ld_data, loader_download,
             execute_addr, execute_enable, error
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, ld_ack,
      output ioctl_wait, ld_wr, ld_addr, ld_data, loader_download,
             execute_addr, execute_enable, error
   );
endinterface

// File: rtl/cmd_record_loader.sv
// TRS-80 /CMD load-module parser: streams data records into RAM with an
// acknowledge handshake, skips other records and captures the transfer address.
module cmd_record_loader #(
   parameter int unsigned ADDR_W    = 16,
   parameter logic [7:0]  INDEX     = 8'd2,
   parameter bit          AUTO_EXEC = 1'b1
) (
   input logic                clk_sys,
   input logic                reset_n,
   cmd_record_loader_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_TYPE  = 4'd1,
      S_LEN   = 4'd2,
      S_ADLO  = 4'd3,
      S_ADHI  = 4'd4,
      S_DATA  = 4'd5,
      S_WRITE = 4'd6,
      S_XLO   = 4'd7,
      S_XHI   = 4'd8,
      S_SKIP  = 4'd9,
      S_DONE  = 4'd10
   } state_e;

   typedef enum logic [1:0] {
      REC_DATA = 2'd0,
      REC_XFER = 2'd1,
      REC_SKIP = 2'd2
   } rec_e;

   // The length byte of a data record also counts the two address bytes.
   function automatic logic [8:0] data_count(input logic [7:0] len);
      logic [7:0] n;
      n = len - 8'd2;
      return (n == 8'd0) ? 9'd256 : {1'b0, n};
   endfunction

   function automatic logic [8:0] skip_count(input logic [7:0] len);
      return (len == 8'd0) ? 9'd256 : {1'b0, len};
   endfunction

   state_e            state_q, state_d;
   rec_e              rec_q, rec_d;
   logic [8:0]        count_q, count_d;
   logic [15:0]       addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic              ld_wr_q, ld_wr_d;
   logic              wait_q, wait_d;
   logic              loader_q, loader_d;
   logic [15:0]       xaddr_q, xaddr_d;
   logic              xen_q, xen_d;
   logic              error_q, error_d;
   logic              dl_prev_q, dl_prev_d;
   logic              byte_ok_s;
   logic              start_s;
   logic [ADDR_W-1:0] ld_addr_s;

   // State and output registers; dl_prev resets high so a download already
   // in progress across reset is not mistaken for a new start.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         rec_q     <= REC_SKIP;
         count_q   <= 9'd0;
         addr_q    <= 16'd0;
         data_q    <= 8'd0;
         ld_wr_q   <= 1'b0;
         wait_q    <= 1'b0;
         loader_q  <= 1'b0;
         xaddr_q   <= 16'd0;
         xen_q     <= 1'b0;
         error_q   <= 1'b0;
         dl_prev_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         rec_q     <= rec_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         ld_wr_q   <= ld_wr_d;
         wait_q    <= wait_d;
         loader_q  <= loader_d;
         xaddr_q   <= xaddr_d;
         xen_q     <= xen_d;
         error_q   <= error_d;
         dl_prev_q <= dl_prev_d;
      end
   end

   // Record parser next-state and output logic
   always_comb begin
      state_d   = state_q;
      rec_d     = rec_q;
      count_d   = count_q;
      addr_d    = addr_q;
      data_d    = data_q;
      ld_wr_d   = ld_wr_q;
      wait_d    = wait_q;
      loader_d  = loader_q;
      xaddr_d   = xaddr_q;
      xen_d     = 1'b0;
      error_d   = error_q;
      dl_prev_d = bus.ioctl_download;
      byte_ok_s = bus.ioctl_wr && !wait_q;
      start_s   = bus.ioctl_download && !dl_prev_q && (bus.ioctl_index == INDEX);

      if (state_q == S_IDLE) begin
         if (start_s) begin
            state_d  = S_TYPE;
            error_d  = 1'b0;
            loader_d = 1'b1;
            xaddr_d  = 16'd0;
         end else begin
            state_d = S_IDLE;
         end
      end else if (!bus.ioctl_download && (state_q != S_WRITE)) begin
         // End of download; a pending write is allowed to finish first.
         state_d  = S_IDLE;
         loader_d = 1'b0;
         ld_wr_d  = 1'b0;
         wait_d   = 1'b0;
         if (state_q == S_DONE) begin
            xen_d = AUTO_EXEC;
         end else if (state_q == S_TYPE) begin
            error_d = error_q;
         end else begin
            error_d = 1'b1;
         end
      end else begin
         case (state_q)
            S_TYPE: begin
               if (byte_ok_s) begin
                  state_d = S_LEN;
                  if (bus.ioctl_dout == 8'h01) begin
                     rec_d = REC_DATA;
                  end else if (bus.ioctl_dout == 8'h02) begin
                     rec_d = REC_XFER;
                  end else begin
                     rec_d = REC_SKIP;
                  end
               end else begin
                  state_d = S_TYPE;
               end
            end
            S_LEN: begin
               if (byte_ok_s) begin
                  case (rec_q)
                     REC_DATA: begin
                        count_d = data_count(bus.ioctl_dout);
                        state_d = S_ADLO;
                     end
                     REC_XFER: state_d = S_XLO;
                     REC_SKIP: begin
                        count_d = skip_count(bus.ioctl_dout);
                        state_d = S_SKIP;
                     end
                     default:  state_d = S_TYPE;
                  endcase
               end else begin
                  state_d = S_LEN;
               end
            end
            S_ADLO: begin
               if (byte_ok_s) begin
                  addr_d[7:0] = bus.ioctl_dout;
                  state_d     = S_ADHI;
               end else begin
                  state_d = S_ADLO;
               end
            end
            S_ADHI: begin
               if (byte_ok_s) begin
                  addr_d[15:8] = bus.ioctl_dout;
                  state_d      = S_DATA;
               end else begin
                  state_d = S_ADHI;
               end
            end
            S_DATA: begin
               if (byte_ok_s) begin
                  data_d  = bus.ioctl_dout;
                  ld_wr_d = 1'b1;
                  wait_d  = 1'b1;
                  state_d = S_WRITE;
               end else begin
                  state_d = S_DATA;
               end
            end
            S_WRITE: begin
               if (bus.ld_ack) begin
                  ld_wr_d = 1'b0;
                  wait_d  = 1'b0;
                  addr_d  = addr_q + 16'd1;
                  count_d = count_q - 9'd1;
                  state_d = (count_q == 9'd1) ? S_TYPE : S_DATA;
               end else begin
                  state_d = S_WRITE;
               end
            end
            S_SKIP: begin
               if (byte_ok_s) begin
                  count_d = count_q - 9'd1;
                  state_d = (count_q == 9'd1) ? S_TYPE : S_SKIP;
               end else begin
                  state_d = S_SKIP;
               end
            end
            S_XLO: begin
               if (byte_ok_s) begin
                  xaddr_d[7:0] = bus.ioctl_dout;
                  state_d      = S_XHI;
               end else begin
                  state_d = S_XLO;
               end
            end
            S_XHI: begin
               if (byte_ok_s) begin
                  xaddr_d[15:8] = bus.ioctl_dout;
                  state_d       = S_DONE;
               end else begin
                  state_d = S_XHI;
               end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // RAM address widened with constant zeros above the 16-bit CPU space
   always_comb begin
      ld_addr_s       = {ADDR_W{1'b0}};
      ld_addr_s[15:0] = addr_q;
   end

   assign bus.ioctl_wait      = wait_q;
   assign bus.ld_wr           = ld_wr_q;
   assign bus.ld_addr         = ld_addr_s;
   assign bus.ld_data         = data_q;
   assign bus.loader_download = loader_q;
   assign bus.execute_addr    = xaddr_q;
   assign bus.execute_enable  = xen_q;
   assign bus.error           = error_q;

endmodule

// File: tb/tb_cmd_record_loader.sv
// Randomised bench for cmd_record_loader: a file-level model predicts the RAM
// writes, the error flag and the execute pulse for each downloaded byte stream.
module tb_cmd_record_loader;

   localparam int unsigned ADDR_W = 20;
   localparam logic [7:0]  IDX    = 8'd2;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;
   int   ack_delay = 0;
   bit   spur_en   = 1'b0;
   int   ack_cnt   = 0;

   wr_t         exp_q[$];
   bit          exp_error;
   bit          exp_exec;
   logic [15:0] exp_xaddr;

   logic              pw, pa, pl;
   logic [ADDR_W-1:0] padr;
   logic [7:0]        pd;
   wr_t               cur;

   cmd_record_loader_if #(.ADDR_W(ADDR_W)) bus ();

   cmd_record_loader #(
      .ADDR_W   (ADDR_W),
      .INDEX    (IDX),
      .AUTO_EXEC(1'b1)
   ) dut (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   // Whole-file interpretation of the /CMD record rules.
   function automatic void model_file(input byte_q_t f);
      int          i, n, cnt;
      logic [7:0]  t, len;
      logic [15:0] a;
      bit          trunc, done;
      wr_t         w;
      exp_q.delete();
      i = 0; n = f.size(); trunc = 1'b0; done = 1'b0; exp_xaddr = 16'h0;
      while (i < n && !done && !trunc) begin
         t = f[i]; i++;
         if (i >= n) trunc = 1'b1;
         else begin
            len = f[i]; i++;
            if (t == 8'h02) begin
               if (i + 2 > n) trunc = 1'b1;
               else begin
                  exp_xaddr = {f[i+1], f[i]};
                  done = 1'b1;
               end
            end else if (t == 8'h01) begin
               cnt = (int'(len) + 254) % 256;
               if (cnt == 0) cnt = 256;
               if (i + 2 > n) trunc = 1'b1;
               else begin
                  a = {f[i+1], f[i]}; i += 2;
                  for (int k = 0; k < cnt; k++) begin
                     if (i >= n) begin
                        trunc = 1'b1;
                        break;
                     end
                     w.a = a; w.d = f[i];
                     exp_q.push_back(w);
                     a = a + 16'd1; i++;
                  end
               end
            end else begin
               cnt = (len == 8'd0) ? 256 : int'(len);
               if (i + cnt > n) trunc = 1'b1;
               else i += cnt;
            end
         end
      end
      exp_error = trunc;
      exp_exec  = done;
   endfunction

   task automatic tick();
      @(posedge clk_sys); #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      while (bus.ioctl_wait && guard < 200) begin
         tick(); guard++;
      end
      chk("wait_bound", guard < 200, 1'b1);
      bus.ioctl_wr = 1'b1; bus.ioctl_dout = b;
      tick();
      bus.ioctl_wr = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic run_file(input byte_q_t f, input int delay, input bit spurious, input bit early_drop);
      int guard;
      ack_delay = delay; spur_en = spurious;
      bus.ioctl_index = IDX; bus.ioctl_download = 1'b1;
      tick();
      chk("loader_start", bus.loader_download, 1'b1);
      chk("error_cleared", bus.error, 1'b0);
      foreach (f[i]) send_byte(f[i]);
      if (!early_drop) begin
         guard = 0;
         while ((bus.ioctl_wait || bus.ld_wr) && guard < 200) begin
            tick(); guard++;
         end
         chk("idle_bound", guard < 200, 1'b1);
      end
      bus.ioctl_download = 1'b0;
      guard = 0;
      while (bus.loader_download && guard < 400) begin
         tick(); guard++;
      end
      chk("end_bound", guard < 400, 1'b1);
      chk("error_end", bus.error, exp_error);
      chk("writes_left", exp_q.size(), 0);
      repeat (2) tick();
   endtask

   task automatic gen_random(output byte_q_t f);
      int          nrec, kind, len, cut;
      logic [15:0] a;
      f.delete();
      nrec = $urandom_range(1, 4);
      for (int r = 0; r < nrec; r++) begin
         kind = $urandom_range(0, 9);
         if (kind < 6) begin
            len = $urandom_range(3, 10);
            a = (kind == 0) ? 16'hFFFD : 16'($urandom);
            f.push_back(8'h01); f.push_back(8'(len));
            f.push_back(a[7:0]); f.push_back(a[15:8]);
            for (int k = 0; k < len - 2; k++) f.push_back(8'($urandom));
         end else if (kind < 9) begin
            len = $urandom_range(1, 6);
            f.push_back(8'(3 + $urandom_range(0, 250))); f.push_back(8'(len));
            for (int k = 0; k < len; k++) f.push_back(8'($urandom));
         end else begin
            a = 16'($urandom);
            f.push_back(8'h02); f.push_back(8'h02);
            f.push_back(a[7:0]); f.push_back(a[15:8]);
            f.push_back(8'($urandom)); f.push_back(8'($urandom));
            break;
         end
      end
      if ($urandom_range(0, 3) == 0) begin
         cut = $urandom_range(1, 3);
         for (int k = 0; k < cut; k++) if (f.size() > 0) void'(f.pop_back());
      end
   endtask

   // RAM side: acknowledge after ack_delay cycles, optional stray acks when idle.
   initial begin
      bus.ld_ack = 1'b0;
      forever begin
         tick();
         if (bus.ld_wr) begin
            if (ack_cnt >= ack_delay) begin
               bus.ld_ack = 1'b1; ack_cnt = 0;
            end else begin
               bus.ld_ack = 1'b0; ack_cnt++;
            end
         end else begin
            ack_cnt = 0;
            bus.ld_ack = spur_en && ($urandom_range(0, 3) == 0);
         end
      end
   end

   // Per-cycle compare against the model on the falling edge.
   initial begin
      pw = 1'b0; pa = 1'b0; pl = 1'b0; padr = '0; pd = 8'h0;
      forever begin
         @(negedge clk_sys);
         if (!reset_n) begin
            pw = 1'b0; pa = 1'b0; pl = 1'b0;
         end else begin
            chk("wait_eq_wr", bus.ioctl_wait, bus.ld_wr);
            chk("addr_upper_zero", bus.ld_addr[ADDR_W-1:16], 32'd0);
            if (pw && !pa) begin
               chk("hold_wr", bus.ld_wr, 1'b1);
               chk("hold_addr", bus.ld_addr, padr);
               chk("hold_data", bus.ld_data, pd);
            end
            if (pw && pa) chk("wr_drop", bus.ld_wr, 1'b0);
            if (bus.ld_wr && bus.ld_ack) begin
               chk("write_expected", exp_q.size() > 0, 1'b1);
               if (exp_q.size() > 0) begin
                  cur = exp_q.pop_front();
                  chk("wr_addr", bus.ld_addr, {16'h0, cur.a});
                  chk("wr_data", bus.ld_data, cur.d);
               end
            end
            if (pl && !bus.loader_download) begin
               chk("exec_pulse", bus.execute_enable, exp_exec);
               if (exp_exec) chk("exec_addr", bus.execute_addr, exp_xaddr);
            end else begin
               chk("no_stray_exec", bus.execute_enable, 1'b0);
            end
            pw = bus.ld_wr; pa = bus.ld_ack; pl = bus.loader_download;
            padr = bus.ld_addr; pd = bus.ld_data;
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: run did not finish, %0d/%0d checks passed so far", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

   initial begin
      byte_q_t f1, f, g;
      bus.ioctl_download = 1'b0; bus.ioctl_index = 8'h0;
      bus.ioctl_wr = 1'b0; bus.ioctl_dout = 8'h0;
      reset_n = 1'b0;
      repeat (3) tick();
      chk("rst_ld_wr", bus.ld_wr, 1'b0);
      chk("rst_wait", bus.ioctl_wait, 1'b0);
      chk("rst_loader", bus.loader_download, 1'b0);
      chk("rst_exec_en", bus.execute_enable, 1'b0);
      chk("rst_error", bus.error, 1'b0);
      chk("rst_ld_addr", bus.ld_addr, 32'd0);
      chk("rst_ld_data", bus.ld_data, 32'd0);
      chk("rst_exec_addr", bus.execute_addr, 32'd0);
      reset_n = 1'b1;
      repeat (2) tick();

      f1 = '{8'h01, 8'h05, 8'h00, 8'h80, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h80};
      model_file(f1);
      chk("model_f1_nwr", exp_q.size(), 3);
      chk("model_f1_w0", exp_q[0], 24'h8000AA);
      chk("model_f1_w2", exp_q[2], 24'h8002CC);
      chk("model_f1_xaddr", exp_xaddr, 16'h8000);
      chk("model_f1_exec", exp_exec, 1'b1);
      run_file(f1, 1, 1'b0, 1'b0);
      chk("f1_exec_addr_held", bus.execute_addr, 16'h8000);
      chk("f1_error", bus.error, 1'b0);

      f = '{8'h01, 8'h02, 8'h00, 8'h70};
      for (int i = 0; i < 256; i++) f.push_back(8'($urandom));
      model_file(f);
      chk("model_l02_nwr", exp_q.size(), 256);
      chk("model_l02_last", exp_q[255].a, 16'h70FF);
      run_file(f, 0, 1'b1, 1'b0);

      f = '{8'h01, 8'h00, 8'h00, 8'h70};
      for (int i = 0; i < 254; i++) f.push_back(8'($urandom));
      model_file(f);
      chk("model_l00_nwr", exp_q.size(), 254);
      run_file(f, 0, 1'b1, 1'b0);

      f = '{8'h05, 8'h03, 8'h41, 8'h42, 8'h43, 8'h01, 8'h04, 8'h00, 8'h90, 8'h11, 8'h22,
            8'h02, 8'h02, 8'h34, 8'h12};
      model_file(f);
      chk("model_skip_w0", exp_q[0], 24'h900011);
      run_file(f, 2, 1'b1, 1'b0);

      f = '{8'h01, 8'h06, 8'h00, 8'hA0, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h02, 8'h02, 8'h00, 8'hA0};
      model_file(f);
      run_file(f, 5, 1'b0, 1'b0);

      f = '{8'h01, 8'h05, 8'h00, 8'h80};
      model_file(f);
      chk("model_trunc_err", exp_error, 1'b1);
      run_file(f, 1, 1'b0, 1'b0);
      chk("trunc_error_set", bus.error, 1'b1);
      model_file(f1);
      run_file(f1, 1, 1'b0, 1'b0);

      f = '{8'h01, 8'h04, 8'hFF, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h02, 8'hFF, 8'hFF};
      model_file(f);
      chk("model_wrap_w1", exp_q[1], 24'h0000A5);
      run_file(f, 0, 1'b0, 1'b0);

      f = '{8'h01, 8'h04, 8'h00, 8'hB0, 8'h01, 8'h02};
      model_file(f);
      run_file(f, 5, 1'b0, 1'b1);

      g = '{8'h01, 8'h03, 8'h00, 8'h80, 8'h11, 8'h22};
      exp_q.delete();
      bus.ioctl_index = 8'd5; bus.ioctl_download = 1'b1;
      tick();
      foreach (g[i]) begin
         bus.ioctl_wr = 1'b1; bus.ioctl_dout = g[i];
         tick();
         bus.ioctl_wr = 1'b0;
         chk("other_idx_loader", bus.loader_download, 1'b0);
         chk("other_idx_wr", bus.ld_wr, 1'b0);
      end
      bus.ioctl_download = 1'b0;
      repeat (2) tick();

      for (int r = 0; r < 8; r++) begin
         gen_random(f);
         model_file(f);
         run_file(f, $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
      end

      f = '{8'h01, 8'h06, 8'h00, 8'hC0, 8'h11, 8'h22, 8'h33, 8'h44};
      model_file(f);
      ack_delay = 40; spur_en = 1'b0;
      bus.ioctl_index = IDX; bus.ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) send_byte(f[i]);
      chk("rst_test_pending", bus.ld_wr, 1'b1);
      #3 reset_n = 1'b0;
      #1;
      exp_q.delete();
      chk("abort_ld_wr", bus.ld_wr, 1'b0);
      chk("abort_wait", bus.ioctl_wait, 1'b0);
      chk("abort_loader", bus.loader_download, 1'b0);
      chk("abort_ld_addr", bus.ld_addr, 32'd0);
      chk("abort_ld_data", bus.ld_data, 32'd0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.ioctl_wr = 1'b1; bus.ioctl_dout = 8'($urandom);
         tick();
         bus.ioctl_wr = 1'b0;
         chk("post_rst_no_wr", bus.ld_wr, 1'b0);
         chk("post_rst_loader", bus.loader_download, 1'b0);
      end
      bus.ioctl_download = 1'b0;
      repeat (3) tick();
      model_file(f1);
      run_file(f1, 1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
